// File: rtl/cu_pkg.sv
// Shared definitions for the SHA-256 cracking unit: round constants, initial
// hash values, FSM state encoding and the SHA-256 bitwise helper functions.
// No ports; imported by sha256_round and sha256_cracking_unit.
package cu_pkg;

  localparam int MAX_BYTES = 32;

  typedef enum logic [1:0] {LOAD, ROUND, FINAL, DONE} cu_state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
// Latency: 0 cycles. No flow control: purely combinational.
// Ports: state_i {a..h} (a in [255:224]), k_i round constant, w_i schedule
//        word, state_o next {a..h}.
module sha256_round
  import cu_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [31:0]  k_i,
  input  logic [31:0]  w_i,
  output logic [255:0] state_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_i;

  assign t1 = h + Sigma1(e) + ch(e, f, g) + k_i + w_i;
  assign t2 = Sigma0(a) + maj(a, b, c);

  assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_cracking_unit.sv
// Single-block SHA-256 core: captures message on leaving reset, pads it, runs
// 64 rounds (one per clock) and presents the digest.
// Latency: hashing_done on the 66th edge after reset release (2nd on overflow).
// No backpressure: self-starting; inputs sampled only in LOAD.
// Ports: clk, reset (async active-high), data[255:0] (right-aligned message),
//        data_length[63:0] (bytes), Hash_Digest[255:0] (H0 in [255:224]),
//        overflow_err (length > 32), hashing_done (digest valid).
// Build option CU_AUTO_RESTART_EN: DONE lasts one cycle and the unit returns to
// LOAD, giving a 1-cycle hashing_done pulse every 67 cycles. Otherwise one-shot.
module sha256_cracking_unit
  import cu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] data,
  input  logic [63:0]  data_length,
  output logic [255:0] Hash_Digest,
  output logic         overflow_err,
  output logic         hashing_done
);

  cu_state_e    state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic [255:0] abc_q, abc_d;
  logic [31:0]  w_q [0:15];
  logic [31:0]  w_d [0:15];
  logic [255:0] digest_q, digest_d;
  logic         ovf_q, ovf_d;
  logic         done_q, done_d;

  logic [255:0] abc_rnd;
  logic [31:0]  w_new;
  logic [511:0] blk;
  logic [5:0]   len6;
  logic [8:0]   msg_shift;

  // Only meaningful when length <= 32, where the low 6 bits hold it exactly.
  assign len6      = data_length[5:0];
  assign msg_shift = 9'd256 - {len6, 3'b000};

  // Left-justify the message (bytes beyond L fall off the top), place the 0x80
  // marker at byte L, and the bit length in the last 64 bits.
  assign blk = ({data, 256'b0} << msg_shift)
             | ({8'h80, 504'b0} >> {len6, 3'b000})
             | {503'b0, len6, 3'b000};

  sha256_round u_round (
    .state_i (abc_q),
    .k_i     (K[t_q]),
    .w_i     (w_q[0]),
    .state_o (abc_rnd)
  );

  // Window holds W[t..t+15]; the word appended is W[t+16].
  assign w_new = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    abc_d    = abc_q;
    w_d      = w_q;
    digest_d = digest_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    unique case (state_q)
      LOAD: begin
`ifdef CU_AUTO_RESTART_EN
        done_d = 1'b0;
`endif
        if (data_length > 64'(MAX_BYTES)) begin
          ovf_d    = 1'b1;
          digest_d = '0;
          state_d  = DONE;
        end else begin
          for (int i = 0; i < 16; i++) w_d[i] = blk[511 - 32*i -: 32];
          for (int i = 0; i < 8; i++)  abc_d[255 - 32*i -: 32] = H_INIT[i];
          t_d     = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        abc_d = abc_rnd;
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_new;
        t_d     = t_q + 6'd1;
        if (t_q == 6'd63) state_d = FINAL;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++)
          digest_d[255 - 32*i -: 32] = H_INIT[i] + abc_q[255 - 32*i -: 32];
        ovf_d   = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
`ifdef CU_AUTO_RESTART_EN
        // After FINAL ovf_q is already 0, so only an overflow pass raises
        // done here; a normal pass ends its one-cycle pulse.
        done_d  = ovf_q;
        state_d = LOAD;
`else
        done_d  = 1'b1;
`endif
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      t_q      <= '0;
      abc_q    <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      digest_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      abc_q    <= abc_d;
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
      digest_q <= digest_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign Hash_Digest  = digest_q;
  assign overflow_err = ovf_q;
  assign hashing_done = done_q;

endmodule

// File: tb/tb_sha256_cracking_unit.sv
// Directed testbench for sha256_cracking_unit: known SHA-256 vectors, overflow,
// mid-hash reset and input changes after LOAD. Outputs sampled 1 time unit
// after the rising edge.
module tb_sha256_cracking_unit;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] data = '0;
  logic [63:0]  data_length = '0;
  logic [255:0] Hash_Digest;
  logic         overflow_err;
  logic         hashing_done;

  int errors = 0;
  int checks = 0;

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_HELLO = 256'h2cf24dba5fb0a30e26e83b2ac5b9e29e1b161e5c1fa7425e73043362938b9824;
  localparam logic [255:0] MSG_ABC   = 256'h616263;
  localparam logic [255:0] MSG_HELLO = 256'h68656c6c6f;

  always #5 clk = ~clk;

  sha256_cracking_unit dut (
    .clk          (clk),
    .reset        (reset),
    .data         (data),
    .data_length  (data_length),
    .Hash_Digest  (Hash_Digest),
    .overflow_err (overflow_err),
    .hashing_done (hashing_done)
  );

  // Hold reset, apply inputs, release on a falling edge so the next rising
  // edge is edge 1 (LOAD).
  task automatic start_hash(input logic [255:0] d, input logic [63:0] l);
    reset = 1'b1;
    data = d;
    data_length = l;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    data = MSG_ABC;
    data_length = 64'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({Hash_Digest, overflow_err, hashing_done} !== 258'b0) begin
      errors++;
      $display("FAIL reset_state: got dig=%h ovf=%b done=%b required all zero",
               Hash_Digest, overflow_err, hashing_done);
    end
  endtask

  task automatic test_vector(input string name, input logic [255:0] d,
                             input logic [63:0] l, input logic [255:0] dig);
    start_hash(d, l);
    edges(65);
    checks++;
    if (hashing_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_early_done: got %b at edge 65 required 0", name, hashing_done);
    end
    edges(1);
    checks++;
    if (hashing_done !== 1'b1 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got done=%b ovf=%b at edge 66 required 1/0",
               name, hashing_done, overflow_err);
    end
    checks++;
    if (Hash_Digest !== dig) begin
      errors++;
      $display("FAIL %s_digest: got %h required %h", name, Hash_Digest, dig);
    end
  endtask

  task automatic test_overflow;
    start_hash(MSG_ABC, 64'd33);
    edges(1);
    checks++;
    if (overflow_err !== 1'b1 || hashing_done !== 1'b0 || Hash_Digest !== 256'b0) begin
      errors++;
      $display("FAIL overflow_edge1: got ovf=%b done=%b dig=%h required 1/0/0",
               overflow_err, hashing_done, Hash_Digest);
    end
    edges(1);
    checks++;
    if (overflow_err !== 1'b1 || hashing_done !== 1'b1 || Hash_Digest !== 256'b0) begin
      errors++;
      $display("FAIL overflow_edge2: got ovf=%b done=%b dig=%h required 1/1/0",
               overflow_err, hashing_done, Hash_Digest);
    end
    // Only the upper bits exceed the limit: must still flag overflow.
    start_hash(MSG_ABC, 64'h1_0000_0003);
    edges(2);
    checks++;
    if (overflow_err !== 1'b1 || hashing_done !== 1'b1) begin
      errors++;
      $display("FAIL overflow_wide_len: got ovf=%b done=%b required 1/1",
               overflow_err, hashing_done);
    end
  endtask

  task automatic test_reset_midhash;
    // Finish a hash so outputs are nonzero, then check reset clears them
    // without a clock edge.
    start_hash(MSG_HELLO, 64'd5);
    edges(66);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({Hash_Digest, overflow_err, hashing_done} !== 258'b0) begin
      errors++;
      $display("FAIL async_reset_clear: got dig=%h done=%b required zero",
               Hash_Digest, hashing_done);
    end
    // Pulse reset at edge 30 of an "abc" hash.
    start_hash(MSG_ABC, 64'd3);
    edges(30);
    reset = 1'b1;
    #1;
    checks++;
    if ({Hash_Digest, overflow_err, hashing_done} !== 258'b0) begin
      errors++;
      $display("FAIL midhash_reset_outputs: got dig=%h done=%b required zero",
               Hash_Digest, hashing_done);
    end
    @(negedge clk);
    reset = 1'b0;
    edges(65);
    checks++;
    if (hashing_done !== 1'b0) begin
      errors++;
      $display("FAIL midhash_restart_early: got done=%b at edge 65 required 0", hashing_done);
    end
    edges(1);
    checks++;
    if (hashing_done !== 1'b1 || Hash_Digest !== DIG_ABC) begin
      errors++;
      $display("FAIL midhash_restart_digest: got done=%b dig=%h required 1/%h",
               hashing_done, Hash_Digest, DIG_ABC);
    end
  endtask

  task automatic test_data_change;
    start_hash(MSG_ABC, 64'd3);
    edges(10);
    data = MSG_HELLO;
    data_length = 64'd5;
    edges(56);
    checks++;
    if (hashing_done !== 1'b1 || Hash_Digest !== DIG_ABC) begin
      errors++;
      $display("FAIL data_change_digest: got done=%b dig=%h required 1/%h",
               hashing_done, Hash_Digest, DIG_ABC);
    end
`ifdef CU_AUTO_RESTART_EN
    edges(1);
    checks++;
    if (hashing_done !== 1'b0 || Hash_Digest !== DIG_ABC) begin
      errors++;
      $display("FAIL auto_pulse_end: got done=%b dig=%h required 0/%h",
               hashing_done, Hash_Digest, DIG_ABC);
    end
    edges(65);
    checks++;
    if (hashing_done !== 1'b0) begin
      errors++;
      $display("FAIL auto_second_early: got done=%b at edge 132 required 0", hashing_done);
    end
    edges(1);
    checks++;
    if (hashing_done !== 1'b1 || Hash_Digest !== DIG_HELLO) begin
      errors++;
      $display("FAIL auto_second_digest: got done=%b dig=%h required 1/%h",
               hashing_done, Hash_Digest, DIG_HELLO);
    end
`else
    edges(20);
    checks++;
    if (hashing_done !== 1'b1 || overflow_err !== 1'b0 || Hash_Digest !== DIG_ABC) begin
      errors++;
      $display("FAIL done_hold: got done=%b ovf=%b dig=%h required 1/0/%h",
               hashing_done, overflow_err, Hash_Digest, DIG_ABC);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_vector("abc", MSG_ABC, 64'd3, DIG_ABC);
    test_vector("empty", 256'h0, 64'd0, DIG_EMPTY);
    // Garbage above the message length must be ignored.
    test_vector("hello", {216'hdeadbeef, 40'h68656c6c6f}, 64'd5, DIG_HELLO);
    test_overflow();
    test_reset_midhash();
    test_data_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
